wtc_7seg_cmd_seq: RTL and testbench

Command initiator for the team's 7-segment control library. It accepts a display request over a valid/ready handshake: a binary value 0-99, a brightness divisor, a display mode, and an optional reset. It converts the value to two decimal digits sequentially, then drives the ordered mode/value command stream onto the 7-segment command port. It sits between application logic (counters, UART parsers) and the segment driver.

---
 rtl/wtc_7seg_cmd_seq.sv | 167 ++++++++++++++++
 tb/tb_wtc_7seg_cmd_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/wtc_7seg_cmd_seq.sv
// Display request front end for the 7-segment library: converts a 0-99 value to
// decimal digits and issues the ordered mode/value command stream to the segment driver.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for a request, re-driving the last display mode
// CONV   | repeated-subtraction binary to tens/ones conversion
// RST    | RESET command (001), only when the request asked for it
// BRIGHT | brightness command (111)
// TENS   | tens digit command (010)
// ONES   | ones digit command (011)
// MODE   | display mode command (000), then back to IDLE
module wtc_7seg_cmd_seq #(
  parameter int         CMD_HOLD          = 2,
  parameter logic [3:0] DEFAULT_DISP_MODE = 4'd0
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic [7:0] i_value,
  input  logic [4:0] i_bright,
  input  logic [3:0] i_disp_mode,
  input  logic       i_do_reset,
  output logic [2:0] o_mode,
  output logic [4:0] o_value,
  output logic       o_busy,
  output logic       o_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CONV   = 3'd1,
    RST    = 3'd2,
    BRIGHT = 3'd3,
    TENS   = 3'd4,
    ONES   = 3'd5,
    MODE   = 3'd6
  } state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(CMD_HOLD - 1);

  state_t     state, state_nxt;
  logic [7:0] hold_q, hold_nxt;
  logic [6:0] rem_q, rem_nxt;
  logic [3:0] tens_q, tens_nxt;
  logic [4:0] bright_q;
  logic [3:0] disp_q;
  logic       do_rst_q;
  logic [2:0] mode_nxt;
  logic [4:0] value_nxt;
  logic       ready_nxt;
  logic       accept;
  logic [6:0] value_clamped;

  assign accept        = i_req_valid && o_req_ready;
  assign value_clamped = (i_value > 8'd99) ? 7'd99 : i_value[6:0];

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state       <= IDLE;
      hold_q      <= 8'd0;
      rem_q       <= 7'd0;
      tens_q      <= 4'd0;
      bright_q    <= 5'd0;
      disp_q      <= DEFAULT_DISP_MODE;
      do_rst_q    <= 1'b0;
      o_mode      <= 3'b000;
      o_value     <= {1'b0, DEFAULT_DISP_MODE};
      o_req_ready <= 1'b0;
      o_busy      <= 1'b1;
      o_err       <= 1'b0;
    end else begin
      state       <= state_nxt;
      hold_q      <= hold_nxt;
      rem_q       <= rem_nxt;
      tens_q      <= tens_nxt;
      o_mode      <= mode_nxt;
      o_value     <= value_nxt;
      o_req_ready <= ready_nxt;
      o_busy      <= ~ready_nxt;
      if (accept) begin
        bright_q <= i_bright;
        disp_q   <= i_disp_mode;
        do_rst_q <= i_do_reset;
        o_err    <= (i_value > 8'd99);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_q;
    rem_nxt   = rem_q;
    tens_nxt  = tens_q;
    mode_nxt  = o_mode;
    value_nxt = o_value;

    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = CONV;
          rem_nxt   = value_clamped;
          tens_nxt  = 4'd0;
        end
      end
      CONV: begin
        if (rem_q >= 7'd10) begin
          rem_nxt  = rem_q - 7'd10;
          tens_nxt = tens_q + 4'd1;
        end else begin
          state_nxt = do_rst_q ? RST : BRIGHT;
        end
      end
      RST, BRIGHT, TENS, ONES, MODE: begin
        if (hold_q == 8'd0) begin
          case (state)
            RST:     state_nxt = BRIGHT;
            BRIGHT:  state_nxt = TENS;
            TENS:    state_nxt = ONES;
            ONES:    state_nxt = MODE;
            default: state_nxt = IDLE;
          endcase
        end else begin
          hold_nxt = hold_q - 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Command outputs only change on the edge entering a command state;
    // IDLE and CONV keep whatever was last driven.
    if (state_nxt != state) begin
      case (state_nxt)
        RST: begin
          mode_nxt  = 3'b001;
          value_nxt = 5'd0;
          hold_nxt  = HOLD_LOAD;
        end
        BRIGHT: begin
          mode_nxt  = 3'b111;
          value_nxt = bright_q;
          hold_nxt  = HOLD_LOAD;
        end
        TENS: begin
          mode_nxt  = 3'b010;
          value_nxt = {1'b0, tens_q};
          hold_nxt  = HOLD_LOAD;
        end
        ONES: begin
          mode_nxt  = 3'b011;
          value_nxt = {1'b0, rem_q[3:0]};
          hold_nxt  = HOLD_LOAD;
        end
        MODE: begin
          mode_nxt  = 3'b000;
          value_nxt = {1'b0, disp_q};
          hold_nxt  = HOLD_LOAD;
        end
        default: ;
      endcase
    end

    ready_nxt = (state_nxt == IDLE);
  end

endmodule

// File: tb/tb_wtc_7seg_cmd_seq.sv
// Directed bench for wtc_7seg_cmd_seq: request vectors with hand-computed digit,
// conversion length and busy-cycle expectations, plus mid-sequence reset.
module tb_wtc_7seg_cmd_seq;

  localparam int HOLD = 2;

  logic       i_Clk = 1'b0;
  logic       i_Reset;
  logic       i_req_valid;
  logic       o_req_ready;
  logic [7:0] i_value;
  logic [4:0] i_bright;
  logic [3:0] i_disp_mode;
  logic       i_do_reset;
  logic [2:0] o_mode;
  logic [4:0] o_value;
  logic       o_busy;
  logic       o_err;

  int n_tests = 0;
  int n_fail  = 0;

  wtc_7seg_cmd_seq #(.CMD_HOLD(HOLD), .DEFAULT_DISP_MODE(4'd0)) dut (
    .i_Clk       (i_Clk),
    .i_Reset     (i_Reset),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_value     (i_value),
    .i_bright    (i_bright),
    .i_disp_mode (i_disp_mode),
    .i_do_reset  (i_do_reset),
    .o_mode      (o_mode),
    .o_value     (o_value),
    .o_busy      (o_busy),
    .o_err       (o_err)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!o_req_ready && k < 100) begin
      step();
      k++;
    end
    if (!o_req_ready) check("wait_ready_timeout", 32'(o_req_ready), 32'd1);
  endtask

  // Issue one request and walk the whole command stream cycle by cycle.
  task automatic run_req(input logic [7:0] v, input logic [4:0] b, input logic [3:0] dm,
                         input logic dr, input int conv, input logic [3:0] tn,
                         input logic [3:0] on, input int busy_exp, input logic err_exp,
                         input logic hold_valid);
    logic [7:0] prev;
    logic [7:0] cmds[5];
    int         ncmd;
    int         busy_seen;
    int         j;
    wait_ready();
    prev        = {o_mode, o_value};
    i_value     = v;
    i_bright    = b;
    i_disp_mode = dm;
    i_do_reset  = dr;
    i_req_valid = 1'b1;
    step();
    if (!hold_valid) i_req_valid = 1'b0;
    check("accept_ready", 32'(o_req_ready), 32'd0);
    check("err", 32'(o_err), 32'(err_exp));

    ncmd = 0;
    if (dr) begin
      cmds[ncmd] = {3'b001, 5'd0};
      ncmd++;
    end
    cmds[ncmd] = {3'b111, b};          ncmd++;
    cmds[ncmd] = {3'b010, 1'b0, tn};   ncmd++;
    cmds[ncmd] = {3'b011, 1'b0, on};   ncmd++;
    cmds[ncmd] = {3'b000, 1'b0, dm};   ncmd++;

    busy_seen = 0;
    j = 0;
    for (int k = 0; k < conv; k++) begin
      check("conv_cmd", 32'({o_mode, o_value}), 32'(prev));
      busy_seen += int'(o_busy);
      if (hold_valid) begin
        i_value = 8'(8'd90 + 8'(j));
        j++;
      end
      step();
    end
    for (int c = 0; c < ncmd; c++) begin
      for (int h = 0; h < HOLD; h++) begin
        check("cmd", 32'({o_mode, o_value}), 32'(cmds[c]));
        busy_seen += int'(o_busy);
        if (hold_valid) begin
          i_value = 8'(8'd90 + 8'(j));
          j++;
        end
        step();
      end
    end
    check("ready_back", 32'(o_req_ready), 32'd1);
    check("busy_low", 32'(o_busy), 32'd0);
    check("busy_cycles", 32'(busy_seen), 32'(busy_exp));
  endtask

  initial begin
    i_Reset     = 1'b1;
    i_req_valid = 1'b0;
    i_value     = 8'd0;
    i_bright    = 5'd0;
    i_disp_mode = 4'd0;
    i_do_reset  = 1'b0;

    // Power-up reset, 3 cycles.
    step();
    check("rst_ready", 32'(o_req_ready), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd1);
    step();
    step();
    i_Reset = 1'b0;
    step();
    check("post_rst_ready", 32'(o_req_ready), 32'd1);
    check("post_rst_cmd", 32'({o_mode, o_value}), 32'h00);
    check("post_rst_err", 32'(o_err), 32'd0);

    //       v      b      dm    dr  conv tens  ones  busy err hold
    run_req(8'd42, 5'd3,  4'd1, 0,  5,   4'd4, 4'd2, 13,  0,  0);
    run_req(8'd7,  5'd5,  4'd2, 1,  1,   4'd0, 4'd7, 11,  0,  0);
    run_req(8'd200,5'd1,  4'd3, 0,  10,  4'd9, 4'd9, 18,  1,  0);
    check("err_sticky", 32'(o_err), 32'd1);
    run_req(8'd5,  5'd0,  4'd4, 0,  1,   4'd0, 4'd5, 9,   0,  0);
    check("idle_cmd", 32'({o_mode, o_value}), 32'h04);

    // Valid held through busy with junk values; next request lands on the ready cycle.
    run_req(8'd23, 5'd7,  4'd5, 0,  3,   4'd2, 4'd3, 11,  0,  1);
    run_req(8'd61, 5'd2,  4'd6, 0,  7,   4'd6, 4'd1, 15,  0,  0);

    // Reset while the TENS command is on the port.
    wait_ready();
    i_value     = 8'd42;
    i_bright    = 5'd3;
    i_disp_mode = 4'd6;
    i_do_reset  = 1'b0;
    i_req_valid = 1'b1;
    step();
    i_req_valid = 1'b0;
    for (int k = 0; k < 5 + HOLD; k++) step();
    check("tens_before_rst", 32'({o_mode, o_value}), 32'({3'b010, 5'd4}));
    i_Reset     = 1'b1;
    i_req_valid = 1'b1;
    i_value     = 8'd150;
    step();
    i_req_valid = 1'b0;
    check("midrst_cmd", 32'({o_mode, o_value}), 32'h00);
    check("midrst_ready", 32'(o_req_ready), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd1);
    check("midrst_err", 32'(o_err), 32'd0);
    i_Reset = 1'b0;
    step();
    check("midrst_release_ready", 32'(o_req_ready), 32'd1);
    for (int k = 0; k < 8; k++) begin
      check("midrst_quiet", 32'({o_mode, o_value, o_busy}), 32'h000);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
